// File: rtl/bus_arbiter.sv
// Two-client (icache/dcache) arbiter onto one shared bus: holds a grant per transaction
// and steers the single outstanding read response back to the cache that issued it.
module bus_arbiter #(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BUS_TAG_WIDTH  = 13,
    parameter int unsigned WRITE_BEATS    = 8,
    parameter int unsigned RESP_BEATS     = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    // instruction cache
    input  logic                      i_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] i_req,
    input  logic [BUS_TAG_WIDTH-1:0]  i_reqtag,
    output logic                      i_reqack,
    output logic                      i_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] i_resp,
    output logic [BUS_TAG_WIDTH-1:0]  i_resptag,
    input  logic                      i_respack,
    // data cache
    input  logic                      d_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] d_req,
    input  logic [BUS_TAG_WIDTH-1:0]  d_reqtag,
    output logic                      d_reqack,
    output logic                      d_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] d_resp,
    output logic [BUS_TAG_WIDTH-1:0]  d_resptag,
    input  logic                      d_respack,
    // shared bus
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack
);

    localparam int unsigned RespCntW = $clog2(RESP_BEATS + 1);

    typedef enum logic [1:0] {StIdle, StGrantI, StGrantD} state_e;

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;   // 0 = i, 1 = d
    logic                is_write_q, is_write_d;
    logic [3:0]          beat_cnt_q, beat_cnt_d;
    logic                resp_busy_q, resp_busy_d;
    logic                resp_owner_q, resp_owner_d;   // 0 = i, 1 = d
    logic [RespCntW-1:0] resp_cnt_q, resp_cnt_d;

    logic i_elig, d_elig;
    logic accepted;
    logic set_busy;
    logic resp_beat;

    // A read cannot be granted while the previous read's response is still draining.
    assign i_elig = i_reqcyc && !(i_reqtag[BUS_TAG_WIDTH-1] && resp_busy_q);
    assign d_elig = d_reqcyc && !(d_reqtag[BUS_TAG_WIDTH-1] && resp_busy_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b0;
            is_write_q   <= 1'b0;
            beat_cnt_q   <= '0;
            resp_busy_q  <= 1'b0;
            resp_owner_q <= 1'b0;
            resp_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            is_write_q   <= is_write_d;
            beat_cnt_q   <= beat_cnt_d;
            resp_busy_q  <= resp_busy_d;
            resp_owner_q <= resp_owner_d;
            resp_cnt_q   <= resp_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        is_write_d   = is_write_q;
        beat_cnt_d   = beat_cnt_q;
        set_busy     = 1'b0;
        bus_reqcyc   = 1'b0;
        bus_req      = '0;
        bus_reqtag   = '0;
        i_reqack     = 1'b0;
        d_reqack     = 1'b0;

        unique case (state_q)
            StIdle: begin
                // On a tie the client that did not win last time gets the bus.
                if (i_elig && (!d_elig || last_grant_q)) begin
                    state_d      = StGrantI;
                    last_grant_d = 1'b0;
                    beat_cnt_d   = '0;
                end else if (d_elig) begin
                    state_d      = StGrantD;
                    last_grant_d = 1'b1;
                    beat_cnt_d   = '0;
                end
            end
            StGrantI: begin
                bus_reqcyc = i_reqcyc;
                bus_req    = i_req;
                bus_reqtag = i_reqtag;
                i_reqack   = bus_reqack;
            end
            StGrantD: begin
                bus_reqcyc = d_reqcyc;
                bus_req    = d_req;
                bus_reqtag = d_reqtag;
                d_reqack   = bus_reqack;
            end
            default: state_d = StIdle;
        endcase

        accepted = bus_reqcyc && bus_reqack;

        if (state_q != StIdle && accepted) begin
            if (beat_cnt_q == 4'd0) begin
                is_write_d = ~bus_reqtag[BUS_TAG_WIDTH-1];
                if (bus_reqtag[BUS_TAG_WIDTH-1]) begin
                    set_busy = 1'b1;
                    state_d  = StIdle;
                end else begin
                    beat_cnt_d = 4'd1;
                end
            end else if (is_write_q) begin
                if (beat_cnt_q == 4'(WRITE_BEATS)) begin
                    beat_cnt_d = '0;
                    state_d    = StIdle;
                end else begin
                    beat_cnt_d = beat_cnt_q + 4'd1;
                end
            end
        end
    end

    assign i_resp      = bus_resp;
    assign i_resptag   = bus_resptag;
    assign d_resp      = bus_resp;
    assign d_resptag   = bus_resptag;
    assign i_respcyc   = resp_busy_q && !resp_owner_q && bus_respcyc;
    assign d_respcyc   = resp_busy_q && resp_owner_q && bus_respcyc;
    assign bus_respack = resp_busy_q && (resp_owner_q ? d_respack : i_respack);
    assign resp_beat   = bus_respcyc && bus_respack;

    always_comb begin
        resp_busy_d  = resp_busy_q;
        resp_owner_d = resp_owner_q;
        resp_cnt_d   = resp_cnt_q;
        if (resp_beat) begin
            if (resp_cnt_q == RespCntW'(RESP_BEATS - 1)) begin
                resp_busy_d = 1'b0;
                resp_cnt_d  = '0;
            end else begin
                resp_cnt_d = resp_cnt_q + 1'b1;
            end
        end
        // A new read header overrides a clear landing in the same cycle.
        if (set_busy) begin
            resp_busy_d  = 1'b1;
            resp_owner_d = (state_q == StGrantD);
            resp_cnt_d   = '0;
        end
    end

endmodule
